led_blink_sched: RTL and testbench

Round-robin scheduler that shares the board's single status LED among four requesters. Each requester asks for a blink program (on-time, period, flash count, all in millisecond ticks). The block grants one requester at a time, runs that program to completion on the LED, and pulses `done` back to it. It sits between application logic (error flags, heartbeat, link status) and the LED pin, and replaces per-source flash counters.

---
 rtl/led_blink_sched.sv | 156 +++++++++++++++
 tb/tb_led_blink_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one active-low status LED among four blink requesters.
// A granted program runs flashes x period ticks of TICK_DIV clocks, then pulses done.
module led_blink_sched #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [47:0] i_on_time,
    input  logic [47:0] i_period,
    input  logic [15:0] i_flashes,
    output logic [3:0]  o_gnt,
    output logic [3:0]  o_done,
    output logic        o_busy,
    output logic        o_led
);

    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [1:0]      r_last;
    logic [3:0]      r_gnt;
    logic [3:0]      r_done;
    logic            r_busy;
    logic            r_led;
    logic [PreW-1:0] r_pre;
    logic [11:0]     r_tick;
    logic [3:0]      r_flash;
    logic [11:0]     r_on;
    logic [11:0]     r_per;
    logic [3:0]      r_fl;

    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_cand;
    logic [11:0] w_sel_on;
    logic [11:0] w_sel_per;
    logic [3:0]  w_sel_fl;
    logic        w_pre_wrap;
    logic        w_tick_wrap;
    logic        w_last;
    logic [11:0] w_tick_nxt;

    // Search starts one past the last grant; k = 4 wraps back to r_last itself (lowest priority).
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_on    = i_on_time[12*w_win +: 12];
        w_sel_per   = i_period[12*w_win +: 12];
        w_sel_fl    = i_flashes[4*w_win +: 4];
        w_pre_wrap  = (r_pre == PreMax);
        w_tick_wrap = w_pre_wrap && (r_tick == r_per - 12'd1);
        w_last      = w_tick_wrap && (r_flash == r_fl - 4'd1);
        if (w_tick_wrap) begin
            w_tick_nxt = 12'd0;
        end else if (w_pre_wrap) begin
            w_tick_nxt = r_tick + 12'd1;
        end else begin
            w_tick_nxt = r_tick;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_idx   <= 2'd0;
            r_last  <= 2'd3;
            r_gnt   <= 4'd0;
            r_done  <= 4'd0;
            r_busy  <= 1'b0;
            r_led   <= 1'b1;
            r_pre   <= '0;
            r_tick  <= 12'd0;
            r_flash <= 4'd0;
            r_on    <= 12'd0;
            r_per   <= 12'd1;
            r_fl    <= 4'd0;
        end else begin
            r_done <= 4'd0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_idx   <= w_win;
                        r_last  <= w_win;
                        r_gnt   <= 4'd1 << w_win;
                        r_busy  <= 1'b1;
                        r_pre   <= '0;
                        r_tick  <= 12'd0;
                        r_flash <= 4'd0;
                        r_on    <= w_sel_on;
                        r_per   <= (w_sel_per == 12'd0) ? 12'd1 : w_sel_per;
                        r_fl    <= w_sel_fl;
                        if (w_sel_fl == 4'd0) begin
                            r_state <= StDone;
                            r_done  <= 4'd1 << w_win;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= StRun;
                            r_led   <= (w_sel_on == 12'd0);
                        end
                    end
                end
                StRun: begin
                    if (!i_req[r_idx]) begin
                        r_state <= StIdle;
                        r_gnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_led   <= 1'b1;
                    end else if (w_last) begin
                        r_state <= StDone;
                        r_done  <= r_gnt;
                        r_led   <= 1'b1;
                    end else begin
                        r_pre  <= w_pre_wrap ? '0 : r_pre + PreW'(1);
                        r_tick <= w_tick_nxt;
                        if (w_tick_wrap) begin
                            r_flash <= r_flash + 4'd1;
                        end
                        // on_time >= period compares true for every tick, giving a fully lit period.
                        r_led <= !(w_tick_nxt < r_on);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_gnt   <= 4'd0;
                    r_busy  <= 1'b0;
                    r_led   <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_led  = r_led;

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched: program table, hand-written corner sequences,
// and randomized traffic against a tick-arithmetic reference model.
module tb_led_blink_sched;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] on_time;
    logic [47:0] period;
    logic [15:0] flashes;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    always #5 clk = ~clk;

    led_blink_sched #(
        .TICK_DIV (TD)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_on_time (on_time),
        .i_period  (period),
        .i_flashes (flashes),
        .o_gnt     (gnt),
        .o_done    (done),
        .o_busy    (busy),
        .o_led     (led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one elapsed-cycle count per program, LED from (k / TD) mod period.
    int         m_mode;  // 0 idle, 1 running, 2 completion cycle
    int         m_idx, m_last, m_k, m_on, m_per, m_fl;
    logic [3:0] m_gnt, m_done;
    logic       m_busy, m_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_idle();
        m_mode = 0;
        m_gnt  = 4'd0;
        m_busy = 1'b0;
        m_led  = 1'b1;
    endtask

    task automatic model_reset();
        model_idle();
        m_last = 3;
        m_done = 4'd0;
    endtask

    task automatic model_step();
        m_done = 4'd0;
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                0: begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= 4; k++) begin
                        if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
                    end
                    if (w >= 0) begin
                        m_idx  = w;
                        m_last = w;
                        m_on   = int'(on_time[12*w +: 12]);
                        m_per  = int'(period[12*w +: 12]);
                        if (m_per == 0) m_per = 1;
                        m_fl   = int'(flashes[4*w +: 4]);
                        m_k    = 0;
                        m_gnt  = 4'd1 << w;
                        m_busy = 1'b1;
                        if (m_fl == 0) begin
                            m_mode = 2;
                            m_done = m_gnt;
                            m_led  = 1'b1;
                        end else begin
                            m_mode = 1;
                            m_led  = !(0 < m_on);
                        end
                    end
                end
                1: begin
                    if (!req[m_idx]) begin
                        model_idle();
                    end else if (m_k == m_fl * m_per * int'(TD) - 1) begin
                        m_mode = 2;
                        m_done = m_gnt;
                        m_led  = 1'b1;
                    end else begin
                        m_k++;
                        m_led = !(((m_k / int'(TD)) % m_per) < m_on);
                    end
                end
                default: model_idle();
            endcase
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag, {22'd0, gnt, done, busy, led}, {22'd0, m_gnt, m_done, m_busy, m_led});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic set_prog(input int idx, input int on, input int per, input int fl);
        on_time[12*idx +: 12] = 12'(on);
        period[12*idx +: 12]  = 12'(per);
        flashes[4*idx +: 4]   = 4'(fl);
    endtask

    task automatic wait_gnt(input string tag, output int cyc);
        cyc = -1;
        for (int c = 0; c < 20; c++) begin
            step(tag);
            if (gnt != 4'd0) begin
                cyc = c + 1;
                break;
            end
        end
    endtask

    task automatic run_prog(input int idx, input int on, input int per, input int fl,
                            output int lat, output int len, output int lit,
                            output logic [3:0] done_bits);
        set_prog(idx, on, per, fl);
        req       = 4'd1 << idx;
        lat       = -1;
        len       = 0;
        lit       = 0;
        done_bits = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            step("prog");
            if (gnt != 4'd0 && lat < 0) lat = c + 1;
            if (done != 4'd0) begin
                done_bits = done;
                break;
            end
            if (gnt != 4'd0) begin
                len++;
                if (!led) lit++;
            end
        end
        req = 4'd0;
        step("prog_idle");
    endtask

    typedef struct {
        int idx;
        int on;
        int per;
        int fl;
        int exp_len;
        int exp_lit;
    } vec_t;

    vec_t vt[6];

    initial begin
        int         lat, len, lit, cyc, ngr;
        logic [3:0] dbits, prev;
        int         gcyc[5];
        logic [3:0] gval[5];
        logic [3:0] rr_exp[5];

        rst = 1'b1;
        req = 4'd0;
        on_time = '0;
        period = '0;
        flashes = '0;
        model_reset();
        step("reset0");
        step("reset1");
        check("reset_gnt", {28'd0, gnt}, 32'd0);
        check("reset_led", {31'd0, led}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step("idle");

        // TICK_DIV = 4: run length = fl*per*4, lit = fl*min(on,per)*4.
        vt[0] = '{0, 2, 5, 3, 60, 24};
        vt[1] = '{1, 0, 2, 1, 8, 0};
        vt[2] = '{3, 7, 3, 2, 24, 24};
        vt[3] = '{2, 1, 0, 2, 8, 8};
        vt[4] = '{1, 3, 4, 1, 16, 12};
        vt[5] = '{2, 5, 5, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            run_prog(vt[i].idx, vt[i].on, vt[i].per, vt[i].fl, lat, len, lit, dbits);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_run_len", i), 32'(len), 32'(vt[i].exp_len));
            check($sformatf("vec%0d_lit", i), 32'(lit), 32'(vt[i].exp_lit));
            check($sformatf("vec%0d_done", i), {28'd0, dbits}, 32'd1 << vt[i].idx);
        end

        // Round robin with all four requesting continuously.
        do_reset();
        on_time = {4{12'd1}};
        period  = {4{12'd1}};
        flashes = {4{4'd1}};
        req = 4'hf;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ngr = 0;
        prev = 4'd0;
        for (int c = 0; c < 60 && ngr < 5; c++) begin
            step("rr");
            if (prev == 4'd0 && gnt != 4'd0) begin
                gval[ngr] = gnt;
                gcyc[ngr] = c;
                ngr++;
            end
            prev = gnt;
        end
        check("rr_count", 32'(ngr), 32'd5);
        for (int i = 0; i < ngr; i++) begin
            check($sformatf("rr_gnt%0d", i), {28'd0, gval[i]}, {28'd0, rr_exp[i]});
            if (i > 0) check($sformatf("rr_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd6);
        end
        req = 4'd0;
        step("rr_end");
        step("rr_end");

        // Abort of requester 1 at RUN cycle 10 with requester 3 pending.
        do_reset();
        set_prog(1, 2, 5, 3);
        set_prog(3, 1, 1, 1);
        req = 4'b1010;
        wait_gnt("ab_wait", cyc);
        check("ab_gnt", {28'd0, gnt}, 32'b0010);
        for (int c = 0; c < 10; c++) step("ab_run");
        req = 4'b1000;
        step("ab_drop");
        check("ab_gnt_off", {28'd0, gnt}, 32'd0);
        check("ab_led_off", {31'd0, led}, 32'd1);
        check("ab_no_done", {28'd0, done}, 32'd0);
        step("ab_next");
        check("ab_gnt3", {28'd0, gnt}, 32'b1000);
        for (int c = 0; c < 8; c++) step("ab_tail");
        req = 4'd0;
        step("ab_idle");

        // Reset in mid-run, then the first grant goes back to requester 0.
        set_prog(2, 2, 5, 3);
        req = 4'b0100;
        wait_gnt("rs_wait", cyc);
        for (int c = 0; c < 5; c++) step("rs_run");
        rst = 1'b1;
        step("rs_pulse");
        check("rs_gnt", {28'd0, gnt}, 32'd0);
        check("rs_led", {31'd0, led}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        req = 4'hf;
        step("rs_regrant");
        check("rs_gnt0", {28'd0, gnt}, 32'b0001);
        req = 4'd0;
        step("rs_idle");

        // Random traffic; params churn every cycle to exercise latching.
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < 4; r++) begin
                set_prog(r, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 499) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
